// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the sync generator to the per-pixel renderers.
// Consumers sample every field on cycles where pix_en is high.
interface vga_sync_gen_if;
  logic       pix_en;
  logic [9:0] xCount;
  logic [9:0] yCount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       update;
  logic [7:0] frame_cnt;

  modport master (
    output pix_en, xCount, yCount, hsync, vsync, video_on, update, frame_cnt
  );

  modport slave (
    input pix_en, xCount, yCount, hsync, vsync, video_on, update, frame_cnt
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing source: clock divider, raster counters, sync/blank decode
// and a once-per-frame update strobe, all registered.
module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // 11-bit boundaries so a sync pulse ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must both be <= 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  logic [DIV_W-1:0] divCntReg;
  logic             pixEnReg;
  logic [9:0]       xCountReg, xCountNext;
  logic [9:0]       yCountReg, yCountNext;
  logic [7:0]       frameCntReg, frameCntNext;
  logic             hsyncReg, hsyncNext;
  logic             vsyncReg, vsyncNext;
  logic             videoOnReg, videoOnNext;
  logic             updateReg, updateNext;
  logic             xWrap, yWrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divCntReg <= '0;
      pixEnReg  <= 1'b0;
    end else if (divCntReg == DIV_LAST) begin
      divCntReg <= '0;
      pixEnReg  <= 1'b1;
    end else begin
      divCntReg <= divCntReg + 1'b1;
      pixEnReg  <= 1'b0;
    end
  end

  always_comb begin
    xWrap        = (xCountReg == X_LAST);
    yWrap        = (yCountReg == Y_LAST);
    xCountNext   = xWrap ? 10'd0 : xCountReg + 10'd1;
    yCountNext   = yCountReg;
    frameCntNext = frameCntReg;
    if (xWrap) begin
      yCountNext = yWrap ? 10'd0 : yCountReg + 10'd1;
      if (yWrap) begin
        frameCntNext = frameCntReg + 8'd1;
      end
    end
    // Decode from the next position so the registered flags line up with it
    hsyncNext   = !(({1'b0, xCountNext} >= HS_START) && ({1'b0, xCountNext} < HS_END));
    vsyncNext   = !(({1'b0, yCountNext} >= VS_START) && ({1'b0, yCountNext} < VS_END));
    videoOnNext = ({1'b0, xCountNext} < H_VIS) && ({1'b0, yCountNext} < V_VIS);
    updateNext  = ({1'b0, yCountNext} == V_VIS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xCountReg   <= '0;
      yCountReg   <= '0;
      frameCntReg <= '0;
      hsyncReg    <= 1'b1;
      vsyncReg    <= 1'b1;
      videoOnReg  <= 1'b0;
      updateReg   <= 1'b0;
    end else if (pixEnReg) begin
      xCountReg   <= xCountNext;
      yCountReg   <= yCountNext;
      frameCntReg <= frameCntNext;
      hsyncReg    <= hsyncNext;
      vsyncReg    <= vsyncNext;
      videoOnReg  <= videoOnNext;
      updateReg   <= updateNext;
    end
  end

  assign vga.pix_en    = pixEnReg;
  assign vga.xCount    = xCountReg;
  assign vga.yCount    = yCountReg;
  assign vga.hsync     = hsyncReg;
  assign vga.vsync     = vsyncReg;
  assign vga.video_on  = videoOnReg;
  assign vga.update    = updateReg;
  assign vga.frame_cnt = frameCntReg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a small-raster CLK_DIV=2 instance and a default-raster
// CLK_DIV=1 instance, both checked every clk against a tick-count model.
module tb_vga_sync_gen;

  // Small raster: 12 x 8 = 96 ticks per frame
  localparam int A_DIV = 2;
  localparam int A_HA = 6, A_HFP = 1, A_HS = 2, A_HBP = 3;
  localparam int A_VA = 4, A_VFP = 1, A_VS = 1, A_VBP = 2;
  localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;
  localparam int B_HA = 640, B_HFP = 16, B_HS = 96, B_HBP = 48;
  localparam int B_VA = 480, B_VFP = 10, B_VS = 2, B_VBP = 33;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;

  logic clk;
  logic rst;
  int   cmpCnt;
  int   errCnt;
  int   kCnt;
  bit   chkEn;
  bit   longEn;
  int   updRise;
  int   fcWrap;
  logic prevUpd;
  logic [7:0] prevFc;

  vga_sync_gen_if ifA ();
  vga_sync_gen_if ifB ();

  vga_sync_gen #(
    .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP)
  ) dutA (
    .clk(clk),
    .rst(rst),
    .vga(ifA)
  );

  vga_sync_gen #(
    .CLK_DIV(1)
  ) dutB (
    .clk(clk),
    .rst(rst),
    .vga(ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clk edges seen since reset was released
  always @(posedge clk or negedge rst) begin
    if (!rst) kCnt <= 0;
    else      kCnt <= kCnt + 1;
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      if (errCnt >= 20) begin
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
      end
    end
  endtask

  // Expected outputs after k clk edges: n ticks have elapsed, position = n mod frame size
  task automatic checkDut(input string nm, input int k, input int div,
                          input int ha, input int hfp, input int hs, input int ht,
                          input int va, input int vfp, input int vs, input int vt,
                          input logic pe, input logic [9:0] x, input logic [9:0] y,
                          input logic hsy, input logic vsy, input logic von,
                          input logic upd, input logic [7:0] fc);
    int n, p, ex, ey;
    logic ePe, eHs, eVs, eVon, eUpd;
    n    = (k == 0) ? 0 : (k - 1) / div;
    p    = n % (ht * vt);
    ex   = p % ht;
    ey   = p / ht;
    ePe  = (k >= 1) && (k % div == 0);
    eHs  = 1'b1;
    eVs  = 1'b1;
    eVon = 1'b0;
    eUpd = 1'b0;
    if (n > 0) begin
      eHs  = !(ex >= ha + hfp && ex < ha + hfp + hs);
      eVs  = !(ey >= va + vfp && ey < va + vfp + vs);
      eVon = (ex < ha) && (ey < va);
      eUpd = (ey == va);
    end
    checkValue({nm, ".pix_en"}, 32'(pe), 32'(ePe));
    checkValue({nm, ".xCount"}, 32'(x), 32'(ex));
    checkValue({nm, ".yCount"}, 32'(y), 32'(ey));
    checkValue({nm, ".hsync"}, 32'(hsy), 32'(eHs));
    checkValue({nm, ".vsync"}, 32'(vsy), 32'(eVs));
    checkValue({nm, ".video_on"}, 32'(von), 32'(eVon));
    checkValue({nm, ".update"}, 32'(upd), 32'(eUpd));
    checkValue({nm, ".frame_cnt"}, 32'(fc), 32'((n / (ht * vt)) % 256));
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkDut("A", kCnt, A_DIV, A_HA, A_HFP, A_HS, A_HT, A_VA, A_VFP, A_VS, A_VT,
               ifA.pix_en, ifA.xCount, ifA.yCount, ifA.hsync, ifA.vsync,
               ifA.video_on, ifA.update, ifA.frame_cnt);
      checkDut("B", kCnt, 1, B_HA, B_HFP, B_HS, B_HT, B_VA, B_VFP, B_VS, B_VT,
               ifB.pix_en, ifB.xCount, ifB.yCount, ifB.hsync, ifB.vsync,
               ifB.video_on, ifB.update, ifB.frame_cnt);
    end
    if (longEn) begin
      if (ifA.update && !prevUpd) updRise++;
      if (prevFc == 8'd255 && ifA.frame_cnt == 8'd0) fcWrap++;
      prevUpd = ifA.update;
      prevFc  = ifA.frame_cnt;
    end
  end

  task automatic checkResetNow(input string tag);
    checkValue({tag, " A.xCount"}, 32'(ifA.xCount), 32'd0);
    checkValue({tag, " A.yCount"}, 32'(ifA.yCount), 32'd0);
    checkValue({tag, " A.pix_en"}, 32'(ifA.pix_en), 32'd0);
    checkValue({tag, " A.hsync"}, 32'(ifA.hsync), 32'd1);
    checkValue({tag, " A.frame_cnt"}, 32'(ifA.frame_cnt), 32'd0);
    checkValue({tag, " B.xCount"}, 32'(ifB.xCount), 32'd0);
    checkValue({tag, " B.pix_en"}, 32'(ifB.pix_en), 32'd0);
    checkValue({tag, " B.video_on"}, 32'(ifB.video_on), 32'd0);
  endtask

  initial begin
    int runLen, offs, hold, kEnd, nEnd, expRise, expWrap;
    cmpCnt  = 0;
    errCnt  = 0;
    chkEn   = 1'b0;
    longEn  = 1'b0;
    updRise = 0;
    fcWrap  = 0;
    prevUpd = 1'b0;
    prevFc  = 8'd0;
    rst     = 1'b0;

    repeat (5) @(posedge clk);
    chkEn = 1'b1;
    #2 rst = 1'b1;
    $display("power-on reset released after 5 clks");

    // Random-length runs, each cut short by a reset landing between clk edges
    for (int seg = 0; seg < 6; seg++) begin
      runLen = $urandom_range(20, 900);
      offs   = $urandom_range(1, 3);
      hold   = $urandom_range(1, 4);
      repeat (runLen) @(posedge clk);
      #(offs) rst = 1'b0;
      #1 checkResetNow("async reset");
      repeat (hold) @(posedge clk);
      #2 rst = 1'b1;
      $display("segment %0d: ran %0d clks, reset at edge+%0d for %0d clks", seg, runLen, offs, hold);
    end

    // Uninterrupted run past 256 small frames
    prevUpd = 1'b0;
    prevFc  = 8'd0;
    updRise = 0;
    fcWrap  = 0;
    longEn  = 1'b1;
    repeat (A_DIV * A_HT * A_VT * 257 + 4) @(posedge clk);
    #1;
    longEn  = 1'b0;
    kEnd    = kCnt - 1;
    nEnd    = (kEnd - 1) / A_DIV;
    expRise = (nEnd >= A_HT * A_VA) ? (nEnd - A_HT * A_VA) / (A_HT * A_VT) + 1 : 0;
    expWrap = nEnd / (A_HT * A_VT * 256);
    checkValue("update rises", 32'(updRise), 32'(expRise));
    checkValue("frame_cnt wraps", 32'(fcWrap), 32'(expWrap));
    $display("long run: %0d ticks, %0d update rises, %0d frame_cnt wraps", nEnd, updRise, fcWrap);

    @(negedge clk);
    chkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
